// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer: frames three UART bytes (operand A, operand B, opcode)
// onto the ALU, then returns the ALU result through the UART transmitter.
// An inter-byte timeout abandons incomplete frames.
//
// Optional feature macro: ALU_SEQ_STATUS_BYTE_EN. When it is defined, a status
// byte {0.., err, carry, neg, zero} follows every result byte.
//
// Handshake semantics: every interface here uses one-cycle strobes with no
// back-pressure. i_rx_done qualifies i_rx_data for exactly one cycle.
// o_tx_start is high for exactly one cycle, and o_tx_data holds its value from
// that cycle until i_tx_done is seen. i_tx_done is honoured only while a byte
// is in flight (WAIT_TX or STAT_WAIT). Bytes that arrive while a frame is
// executing or transmitting are dropped silently.
module alu_uart_sequencer #(
  parameter int                   NB_DATA  = 8,
  parameter int                   NB_OP    = 6,
  parameter int                   TIMEOUT  = 1000000,
  parameter logic [NB_DATA-1:0]   ERR_BYTE = 8'hEE
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_done,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_tx_done,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  output logic [NB_DATA-1:0] o_op_a,
  output logic [NB_DATA-1:0] o_op_b,
  output logic [NB_OP-1:0]   o_opcode,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_error
);

  localparam int NB_CNT = $clog2(TIMEOUT);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(TIMEOUT - 1);

  localparam logic [NB_OP-1:0] OP_ADD = NB_OP'(6'b100000);
  localparam logic [NB_OP-1:0] OP_SUB = NB_OP'(6'b100010);
  localparam logic [NB_OP-1:0] OP_AND = NB_OP'(6'b100100);
  localparam logic [NB_OP-1:0] OP_OR  = NB_OP'(6'b100101);
  localparam logic [NB_OP-1:0] OP_XOR = NB_OP'(6'b100110);
  localparam logic [NB_OP-1:0] OP_NOR = NB_OP'(6'b100111);
  localparam logic [NB_OP-1:0] OP_SRA = NB_OP'(6'b000011);
  localparam logic [NB_OP-1:0] OP_SRL = NB_OP'(6'b000010);

  // The STAT_* states are reachable only when the status byte is enabled.
  typedef enum logic [2:0] {
    GET_A     = 3'd0,
    GET_B     = 3'd1,
    GET_OP    = 3'd2,
    EXEC      = 3'd3,
    WAIT_TX   = 3'd4,
    STAT_SEND = 3'd5,
    STAT_WAIT = 3'd6
  } state_t;

  state_t             state_q,    state_d;
  logic [NB_CNT-1:0]  cnt_q,      cnt_d;
  logic [NB_DATA-1:0] op_a_q,     op_a_d;
  logic [NB_DATA-1:0] op_b_q,     op_b_d;
  logic [NB_OP-1:0]   opcode_q,   opcode_d;
  logic               tx_start_q, tx_start_d;
  logic [NB_DATA-1:0] tx_data_q,  tx_data_d;
  logic               error_q,    error_d;
  // Status flags {err, carry, neg, zero}, captured in EXEC.
  logic [3:0]         status_q,   status_d;
  logic               op_valid;

  function automatic logic is_valid_op(input logic [NB_OP-1:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR,
      OP_XOR, OP_NOR, OP_SRA, OP_SRL: is_valid_op = 1'b1;
      default:                        is_valid_op = 1'b0;
    endcase
  endfunction

  assign op_valid = is_valid_op(opcode_q);

  // Register all state and outputs; reset clears everything and abandons any frame.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= GET_A;
      cnt_q      <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      opcode_q   <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= '0;
      error_q    <= 1'b0;
      status_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      opcode_q   <= opcode_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      error_q    <= error_d;
      status_q   <= status_d;
    end
  end

  // Next-state logic: byte collection, inter-byte timeout, execute and transmit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    opcode_d   = opcode_q;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    error_d    = 1'b0;
    status_d   = status_q;

    case (state_q)
      GET_A: begin
        cnt_d = '0;
        if (i_rx_done) begin
          op_a_d  = i_rx_data;
          state_d = GET_B;
        end
      end

      GET_B: begin
        if (i_rx_done) begin
          op_b_d  = i_rx_data;
          cnt_d   = '0;
          state_d = GET_OP;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      GET_OP: begin
        if (i_rx_done) begin
          opcode_d = i_rx_data[NB_OP-1:0];
          cnt_d    = '0;
          state_d  = EXEC;
        end else if (cnt_q == CNT_LAST) begin
          error_d = 1'b1;
          cnt_d   = '0;
          state_d = GET_A;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      EXEC: begin
        tx_start_d = 1'b1;
        if (op_valid) begin
          tx_data_d = i_alu_result;
        end else begin
          tx_data_d = ERR_BYTE;
          error_d   = 1'b1;
        end
        status_d = {~op_valid, i_alu_carry, i_alu_result[NB_DATA-1],
                    (i_alu_result == '0)};
        state_d  = WAIT_TX;
      end

      WAIT_TX: begin
        if (i_tx_done) begin
`ifdef ALU_SEQ_STATUS_BYTE_EN
          state_d = STAT_SEND;
`else
          state_d = GET_A;
`endif
        end
      end

`ifdef ALU_SEQ_STATUS_BYTE_EN
      STAT_SEND: begin
        tx_start_d = 1'b1;
        tx_data_d  = {{(NB_DATA-4){1'b0}}, status_q};
        state_d    = STAT_WAIT;
      end

      STAT_WAIT: begin
        if (i_tx_done) begin
          state_d = GET_A;
        end
      end
`endif

      default: begin
        state_d = GET_A;
      end
    endcase
  end

  assign o_op_a     = op_a_q;
  assign o_op_b     = op_b_q;
  assign o_opcode   = opcode_q;
  assign o_tx_start = tx_start_q;
  assign o_tx_data  = tx_data_q;
  assign o_error    = error_q;
  assign o_busy     = (state_q != GET_A);

endmodule

// File: tb/tb_alu_uart_sequencer.sv
// Bench for alu_uart_sequencer: directed scenarios plus randomized frames,
// scored against a frame-level reference (ALU function + valid-opcode table).
module tb_alu_uart_sequencer;

  localparam int TO = 16;

  logic       i_clk = 1'b0;
  logic       i_reset;
  logic       i_rx_done;
  logic [7:0] i_rx_data;
  logic       i_tx_done;
  logic [7:0] i_alu_result;
  logic       i_alu_carry;
  logic [7:0] o_op_a;
  logic [7:0] o_op_b;
  logic [5:0] o_opcode;
  logic       o_tx_start;
  logic [7:0] o_tx_data;
  logic       o_busy;
  logic       o_error;

  int checks   = 0;
  int failures = 0;
  int start_cnt = 0;
  logic [7:0] exp_q[$];

  alu_uart_sequencer #(.NB_DATA(8), .NB_OP(6), .TIMEOUT(TO), .ERR_BYTE(8'hEE)) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_rx_done    (i_rx_done),
    .i_rx_data    (i_rx_data),
    .i_tx_done    (i_tx_done),
    .i_alu_result (i_alu_result),
    .i_alu_carry  (i_alu_carry),
    .o_op_a       (o_op_a),
    .o_op_b       (o_op_b),
    .o_opcode     (o_opcode),
    .o_tx_start   (o_tx_start),
    .o_tx_data    (o_tx_data),
    .o_busy       (o_busy),
    .o_error      (o_error)
  );

  // Clock
  always #5 i_clk = ~i_clk;

  // Reference ALU: {carry, result}; unknown opcodes return a recognisable junk value.
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                         input logic [5:0] op);
    logic signed [7:0] s;
    case (op)
      6'b100000: return {1'b0, a} + {1'b0, b};
      6'b100010: return {1'b0, a} - {1'b0, b};
      6'b100100: return {1'b0, a & b};
      6'b100101: return {1'b0, a | b};
      6'b100110: return {1'b0, a ^ b};
      6'b100111: return {1'b0, ~(a | b)};
      6'b000011: begin s = $signed(a) >>> b[2:0]; return {1'b0, s}; end
      6'b000010: return {1'b0, a >> b[2:0]};
      default:   return {1'b1, a ^ 8'h5A};
    endcase
  endfunction

  function automatic bit valid_ref(input logic [5:0] op);
    case (op)
      6'b100000, 6'b100010, 6'b100100, 6'b100101,
      6'b100110, 6'b100111, 6'b000011, 6'b000010: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Environment ALU sitting on the DUT's operand outputs.
  always_comb begin
    {i_alu_carry, i_alu_result} = alu_ref(o_op_a, o_op_b, o_opcode);
  end

  // Count every transmit strobe cycle.
  always @(negedge i_clk) begin
    if (o_tx_start === 1'b1) start_cnt++;
  end

  // Watchdog
  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    i_rx_data = b;
    i_rx_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    i_tx_done = 1'b1;
    @(posedge i_clk);
    #1;
    i_tx_done = 1'b0;
  endtask

  task automatic wait_start(output int lat);
    lat = 0;
    while (o_tx_start !== 1'b1 && lat < 50) begin
      @(posedge i_clk);
      #1;
      lat++;
    end
  endtask

  // One full frame: three bytes, then each transmitted byte is checked and acknowledged.
  task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                           input bit junk);
    logic [8:0] cr;
    logic [7:0] e;
    bit v;
    int lat, s0, nbytes;
    s0 = start_cnt;
    send_byte(a);
    idle($urandom_range(0, 4));
    send_byte(b);
    idle($urandom_range(0, 4));
    send_byte(opb);
    cr = alu_ref(a, b, opb[5:0]);
    v  = valid_ref(opb[5:0]);
    exp_q.push_back(v ? cr[7:0] : 8'hEE);
    nbytes = 1;
`ifdef ALU_SEQ_STATUS_BYTE_EN
    exp_q.push_back({4'b0, ~v, cr[8], cr[7], (cr[7:0] == 8'h00)});
    nbytes = 2;
`endif
    check("op_a", o_op_a, a);
    check("op_b", o_op_b, b);
    check("opcode", o_opcode, opb[5:0]);
    wait_start(lat);
    check("result_latency", lat, 1);
    e = exp_q.pop_front();
    check("result_byte", o_tx_data, e);
    check("result_error", o_error, !v);
    idle(1);
    check("start_one_cycle", o_tx_start, 0);
    if (junk) begin
      send_byte($urandom_range(0, 255));
      check("junk_no_error", o_error, 0);
      check("junk_op_a_kept", o_op_a, a);
    end
    idle($urandom_range(0, 3));
    check("tx_data_stable", o_tx_data, e);
    pulse_tx_done();
`ifdef ALU_SEQ_STATUS_BYTE_EN
    wait_start(lat);
    check("status_latency", lat, 1);
    check("status_byte", o_tx_data, exp_q.pop_front());
    check("status_no_error", o_error, 0);
    idle($urandom_range(1, 3));
    pulse_tx_done();
`endif
    check("busy_after_done", o_busy, 0);
    check("start_count", start_cnt - s0, nbytes);
  endtask

  logic [5:0] valid_ops[8] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101,
                               6'b100110, 6'b100111, 6'b000011, 6'b000010};

  initial begin
    int n, s0;
    logic [7:0] opb;
    i_reset   = 1'b1;
    i_rx_done = 1'b0;
    i_rx_data = 8'h00;
    i_tx_done = 1'b0;
    idle(3);
    i_reset = 1'b0;
    check("rst_op_a", o_op_a, 0);
    check("rst_op_b", o_op_b, 0);
    check("rst_opcode", o_opcode, 0);
    check("rst_tx_start", o_tx_start, 0);
    check("rst_tx_data", o_tx_data, 0);
    check("rst_busy", o_busy, 0);
    check("rst_error", o_error, 0);

    // ADD, invalid opcode, SUB to zero
    run_frame(8'h05, 8'h03, 8'h20, 1'b0);
    run_frame(8'h05, 8'h03, 8'h3F, 1'b0);
    run_frame(8'h03, 8'h03, 8'h22, 1'b0);

    // Timeout after operand A
    send_byte(8'h11);
    n = 0;
    while (o_error !== 1'b1 && n < 40) begin idle(1); n++; end
    check("timeout_a_cycles", n, TO);
    check("timeout_a_busy", o_busy, 0);
    check("timeout_a_op_kept", o_op_a, 8'h11);
    idle(1);
    check("timeout_a_pulse", o_error, 0);
    run_frame(8'h40, 8'h02, 8'h02, 1'b0);

    // Timeout while waiting for the opcode
    send_byte(8'h21);
    send_byte(8'h34);
    n = 0;
    while (o_error !== 1'b1 && n < 40) begin idle(1); n++; end
    check("timeout_op_cycles", n, TO);
    check("timeout_op_b_kept", o_op_b, 8'h34);
    run_frame(8'h81, 8'h01, 8'hC3, 1'b0);

    // Byte arriving on the very last timeout cycle is accepted
    send_byte(8'h07);
    idle(TO - 1);
    send_byte(8'h09);
    check("late_byte_no_error", o_error, 0);
    check("late_byte_busy", o_busy, 1);
    check("late_byte_op_b", o_op_b, 8'h09);
    send_byte(8'h20);
    n = 0;
    while (o_tx_start !== 1'b1 && n < 50) begin idle(1); n++; end
    check("late_frame_latency", n, 1);
    check("late_frame_result", o_tx_data, 8'h10);
    pulse_tx_done();
`ifdef ALU_SEQ_STATUS_BYTE_EN
    idle(1);
    pulse_tx_done();
`endif
    check("late_frame_idle", o_busy, 0);

    // Extra byte during transmission is dropped
    run_frame(8'hF0, 8'h0F, 8'h26, 1'b1);
    run_frame(8'h12, 8'h34, 8'h20, 1'b0);

    // i_tx_done while idle is ignored
    s0 = start_cnt;
    pulse_tx_done();
    idle(2);
    check("stray_done_busy", o_busy, 0);
    check("stray_done_no_start", start_cnt - s0, 0);

    // Reset in GET_OP
    send_byte(8'hAA);
    send_byte(8'h55);
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    check("midrst_op_a", o_op_a, 0);
    check("midrst_op_b", o_op_b, 0);
    check("midrst_opcode", o_opcode, 0);
    check("midrst_tx_data", o_tx_data, 0);
    check("midrst_busy", o_busy, 0);
    check("midrst_error", o_error, 0);
    run_frame(8'h0C, 8'h0A, 8'h24, 1'b0);

    // Reset during WAIT_TX abandons the transmission
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h25);
    idle(2);
    check("inflight_busy", o_busy, 1);
    i_reset = 1'b1;
    idle(1);
    i_reset = 1'b0;
    s0 = start_cnt;
    pulse_tx_done();
    idle(2);
    check("abandoned_busy", o_busy, 0);
    check("abandoned_no_start", start_cnt - s0, 0);
    run_frame(8'h80, 8'h80, 8'h20, 1'b0);

    // Randomized frames
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 3) == 0) opb = 8'($urandom_range(0, 255));
      else opb = {2'($urandom_range(0, 3)), valid_ops[$urandom_range(0, 7)]};
      run_frame(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), opb,
                bit'($urandom_range(0, 1)));
    end

    check("scoreboard_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
